// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel sync + debounce + press/release/long/repeat pulses; in clk,rst,key,repeat_en; out key_level,press_pulse,release_pulse,long_pulse,repeat_pulse
module key_debounce_multi #(
  parameter int NUM_KEYS      = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int LONG_CYCLES   = 1024,
  parameter int REPEAT_CYCLES = 256,
  parameter int ACTIVE_HIGH   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HMAX = LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESSED, HELD} state_t;
  logic [NUM_KEYS-1:0] s1, s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ACTIVE_HIGH != 0 ? key : ~key;
      s2 <= s1;
    end
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_t state, state_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold, hold_n;
    logic lvl, acc, lp_n, rp_n;
    logic prs, rel, lng, rpt;
    always_comb begin
      acc = s2[i] != lvl && cnt == DEB_LAST;
      cnt_n = (s2[i] == lvl || acc) ? '0 : cnt + 1'b1;
      state_n = state;
      hold_n = hold;
      lp_n = 1'b0;
      rp_n = 1'b0;
      if (acc) begin
        state_n = lvl ? RELEASED : PRESSED;
        hold_n = '0;
      end else if (state == PRESSED) begin
        lp_n = hold == LONG_LAST;
        hold_n = lp_n ? '0 : hold + 1'b1;
        state_n = lp_n ? HELD : PRESSED;
      end else if (state == HELD) begin
        rp_n = repeat_en && hold == REP_LAST;
        hold_n = (!repeat_en || rp_n) ? '0 : hold + 1'b1;
      end
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state <= RELEASED;
        cnt <= '0;
        hold <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
        lng <= 1'b0;
        rpt <= 1'b0;
      end else begin
        state <= state_n;
        cnt <= cnt_n;
        hold <= hold_n;
        lvl <= lvl ^ acc;
        prs <= acc & ~lvl;
        rel <= acc & lvl;
        lng <= lp_n;
        rpt <= rp_n;
      end
    assign key_level[i] = lvl;
    assign press_pulse[i] = prs;
    assign release_pulse[i] = rel;
    assign long_pulse[i] = lng;
    assign repeat_pulse[i] = rpt;
  end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: scoreboard bench for key_debounce_multi, active-high and active-low builds
module tb_key_debounce_multi;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, repeat_en = 1'b0;
  logic [N-1:0] key = '0, keyn = '1;
  logic [N-1:0] lvl[2], prs[2], rel[2], lng[2], rpt[2];
  typedef struct {int cyc; int inst; int kind; int ch;} ev_t;
  ev_t q[$];
  int cyc = 0, total = 0, bad = 0;
  string kname[4] = '{"press", "release", "long", "repeat"};
  always #5 clk = ~clk;
  key_debounce_multi #(.NUM_KEYS(N), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_HIGH(1)) dut_h (
    .clk(clk), .rst(rst), .key(key), .repeat_en(repeat_en), .key_level(lvl[0]), .press_pulse(prs[0]),
    .release_pulse(rel[0]), .long_pulse(lng[0]), .repeat_pulse(rpt[0]));
  key_debounce_multi #(.NUM_KEYS(N), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_HIGH(0)) dut_l (
    .clk(clk), .rst(rst), .key(keyn), .repeat_en(repeat_en), .key_level(lvl[1]), .press_pulse(prs[1]),
    .release_pulse(rel[1]), .long_pulse(lng[1]), .repeat_pulse(rpt[1]));
  task automatic push(int c, int d, int k, int ch);
    ev_t e;
    e.cyc = c;
    e.inst = d;
    e.kind = k;
    e.ch = ch;
    q.push_back(e);
  endtask
  task automatic check_ev(int d, int k, int c);
    int idx = -1;
    total++;
    foreach (q[i]) if (idx < 0 && q[i].inst == d && q[i].kind == k && q[i].ch == c) idx = i;
    if (idx < 0) begin
      bad++;
      $display("FAIL %s inst%0d ch%0d: pulse at cycle %0d, required none", kname[k], d, c, cyc);
    end else begin
      if (q[idx].cyc != cyc) begin
        bad++;
        $display("FAIL %s inst%0d ch%0d: pulse at cycle %0d, required cycle %0d", kname[k], d, c, cyc, q[idx].cyc);
      end
      q.delete(idx);
    end
  endtask
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask
  function automatic logic [63:0] all_out();
    return {24'd0, lvl[0], prs[0], rel[0], lng[0], rpt[0], lvl[1], prs[1], rel[1], lng[1], rpt[1]};
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        logic [3:0] v;
        v = {rpt[d][c], lng[d][c], rel[d][c], prs[d][c]};
        for (int k = 0; k < 4; k++) if (v[k]) check_ev(d, k, c);
      end
  end
  initial begin
    int c, p, r;
    #1;
    chk("reset outputs", all_out(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    c = cyc;
    key[0] = 1'b1;
    push(c + 6, 0, 0, 0);
    push(c + 26, 0, 2, 0);
    repeat (5) @(negedge clk);
    chk("level0 before accept", lvl[0][0], 0);
    @(negedge clk);
    chk("level0 after accept", lvl[0][0], 1);
    wait_until(c + 40);
    key[0] = 1'b0;
    push(c + 46, 0, 1, 0);
    wait_until(c + 48);
    chk("level0 after release", lvl[0][0], 0);
    key[1] = 1'b1;
    repeat (3) @(negedge clk);
    key[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch level1", lvl[0][1], 0);
    repeat_en = 1'b1;
    c = cyc;
    p = c + 6;
    key[2] = 1'b1;
    push(p, 0, 0, 2);
    push(p + 20, 0, 2, 2);
    for (int t = 28; t <= 60; t += 8) push(p + t, 0, 3, 2);
    wait_until(p + 60);
    key[2] = 1'b0;
    push(p + 66, 0, 1, 2);
    wait_until(p + 80);
    chk("level2 after release", lvl[0][2], 0);
    c = cyc;
    p = c + 6;
    key[3] = 1'b1;
    push(p, 0, 0, 3);
    push(p + 20, 0, 2, 3);
    wait_until(p + 24);
    repeat_en = 1'b0;
    wait_until(p + 29);
    repeat_en = 1'b1;
    push(p + 37, 0, 3, 3);
    wait_until(p + 40);
    chk("level3 held", lvl[0][3], 1);
    rst = 1'b1;
    #1;
    chk("async reset outputs", all_out(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    push(r + 6, 0, 0, 3);
    wait_until(r + 10);
    chk("level3 repressed", lvl[0][3], 1);
    key[3] = 1'b0;
    push(r + 16, 0, 1, 3);
    wait_until(r + 30);
    c = cyc;
    keyn[0] = 1'b0;
    key[1] = 1'b1;
    push(c + 6, 1, 0, 0);
    push(c + 6, 0, 0, 1);
    wait_until(c + 8);
    chk("active-low level0", lvl[1][0], 1);
    chk("simultaneous level1", lvl[0][1], 1);
    wait_until(c + 10);
    keyn[0] = 1'b1;
    key[1] = 1'b0;
    push(c + 16, 1, 1, 0);
    push(c + 16, 0, 1, 1);
    wait_until(c + 24);
    chk("final levels", {lvl[0], lvl[1]}, 0);
    foreach (q[i]) begin
      total++;
      bad++;
      $display("FAIL missed %s inst%0d ch%0d: no pulse, required cycle %0d", kname[q[i].kind], q[i].inst, q[i].ch, q[i].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
